mult_datapath: RTL

Register datapath for the 4-bit shift-add multiplier. It accepts an operand pair over a valid/ready handshake and pulses `start` to the multiplier controller. It then executes the controller's one-hot strobes (`load_en`, `ADD`, `shift_left`, `shift_right`, `stop`) and presents the product over a valid/ready output stage. It sits between the operand source and the result consumer, with the controller as its only control input.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_result_reg.sv | 50 +++++
 rtl/mult_datapath.sv | 95 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared constants and controller state encodings for the 4-bit shift-add multiplier.
// The datapath, the controller and the benches all take their definitions from here.
package mult_pkg;

  localparam int WIDTH  = 4;
  localparam int PWIDTH = 2 * WIDTH;

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7,
    S8 = 4'd8,
    S9 = 4'd9
  } ctrl_state_e;

endpackage

// File: rtl/mult_result_reg.sv
// Single-entry holding stage for the product: captures on `capture` when empty and
// presents the value until the consumer takes it.
module mult_result_reg
  import mult_pkg::*;
#(
  parameter int DATA_W = PWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;

  // Valid/ready: a transfer happens on any rising edge where out_valid and
  // out_ready are both high; dout stays stable while out_valid is high.
  // A capture while already full is dropped so the held value is never overwritten.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (capture && !valid_q) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout      = data_q;
  assign out_valid = valid_q;
  assign full      = valid_q;

endmodule

// File: rtl/mult_datapath.sv
// Register datapath of the shift-add multiplier: loads operands, executes the
// controller's one-hot strobes and hands the product to the result stage.
module mult_datapath #(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 op_ready,
  output logic                 start,
  output logic [WIDTH-1:0]     Q,
  input  logic                 load_en,
  input  logic                 ADD,
  input  logic                 shift_left,
  input  logic                 shift_right,
  input  logic                 stop,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_valid,
  input  logic                 result_ready
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    m_d, m_q;
  logic [PW-1:0]    p_d, p_q;
  logic [WIDTH-1:0] qr_d, qr_q;
  logic [WIDTH-1:0] qh_d, qh_q;
  logic             start_d, start_q;
  logic             res_full;
  logic             accept;

  // Operand side is valid/ready as well; op_ready never looks at op_valid, and is
  // held low while start is in flight or a product is still waiting for its consumer.
  assign op_ready = load_en & ~start_q & ~res_full;
  assign accept   = op_valid & op_ready;

  // Strobe priority load_en > ADD > shift_left > shift_right.
  always_comb begin
    m_d     = m_q;
    p_d     = p_q;
    qr_d    = qr_q;
    qh_d    = qh_q;
    start_d = accept;
    if (load_en) begin
      if (accept) begin
        m_d  = {{WIDTH{1'b0}}, op_a};
        p_d  = '0;
        qr_d = op_b;
        qh_d = op_b;
      end
    end else if (ADD) begin
      p_d = p_q + m_q;
    end else if (shift_left) begin
      m_d = m_q << 1;
    end else if (shift_right) begin
      qr_d = qr_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q     <= '0;
      p_q     <= '0;
      qr_q    <= '0;
      qh_q    <= '0;
      start_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      p_q     <= p_d;
      qr_q    <= qr_d;
      qh_q    <= qh_d;
      start_q <= start_d;
    end
  end

  assign start = start_q;
  // The controller indexes multiplier bits with its own counter, so Q stays unshifted.
  assign Q     = qh_q;

  mult_result_reg #(
    .DATA_W (PW)
  ) u_result_reg (
    .clk       (clk),
    .reset     (reset),
    .capture   (stop),
    .din       (p_q),
    .dout      (result),
    .out_valid (result_valid),
    .out_ready (result_ready),
    .full      (res_full)
  );

endmodule
